load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-access stage placed directly downstream of the ALU. It takes the ALU result as the effective address for RISC-V RV32I loads and stores. It drives a single-port data-memory request/grant/response interface and returns aligned, sign- or zero-extended load data to writeback. It stalls the pipeline via `busy` while a transfer is outstanding.

## Interface
- `ADDR_WIDTH`, 32, effective-address and memory-address width
- `DATA_WIDTH`, 32, data width; only 32 is supported
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  launch an access; sampled only in IDLE
- `mem_read`  in  1  access is a load
- `mem_write`  in  1  access is a store; wins if both `mem_read` and `mem_write` are high
- `funct3`  in  3  width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are loads only)
- `addr`  in  ADDR_WIDTH  effective address, i.e. the ALU `result`
- `store_data`  in  DATA_WIDTH  rs2 value
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle completion pulse
- `misaligned`  out  1  high with `done` when the access was rejected
- `load_data`  out  DATA_WIDTH  extended load result; valid from `done` until the next accepted `start`
- `dmem_req`  out  1  request valid
- `dmem_we`  out  1  request is a write
- `dmem_addr`  out  ADDR_WIDTH  word-aligned address `{addr[31:2],2'b00}`
- `dmem_wdata`  out  DATA_WIDTH  lane-replicated store data
- `dmem_wstrb`  out  4  byte enables; 0000 for reads
- `dmem_gnt`  in  1  memory accepts the request this cycle
- `dmem_rvalid`  in  1  read data valid
- `dmem_rdata`  in  DATA_WIDTH  read data

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- **IDLE:**
  - `start` is accepted if `mem_read | mem_write`; `start` with neither asserted is ignored.
  - On acceptance, latch `addr`, `funct3`, `store_data` and the direction.
  - A rejected access goes to DONE with the error flag set and issues no request. Rejection occurs for:
    - H/HU with `addr[0]=1`
    - W with `addr[1:0]!=0`
    - an illegal `funct3` (load 011, 110, 111; store anything other than 000, 001, 010)
  - A legal access goes to REQ.
- **REQ:**
  - `dmem_req=1`, with addr/we/wdata/wstrb held stable until `dmem_gnt`.
  - On `gnt`, a store goes to DONE and a load goes to WAIT.
  - `dmem_rvalid` is ignored in REQ.
- **WAIT:**
  - `dmem_req=0`.
  - On `dmem_rvalid`, select the lane by `addr[1:0]` (byte) or `addr[1]` (half), extend it, and register it into `load_data`. Then go to DONE.
  - WAIT has no timeout.
- **DONE:** `done=1` for exactly one cycle, then return to IDLE. `misaligned` follows the latched error flag. `load_data` is not updated on stores or on errors.
- **Store encoding:**
  - SB: wdata=`{4{sd[7:0]}}`, strb=`0001<<addr[1:0]`
  - SH: wdata=`{2{sd[15:0]}}`, strb=`0011<<{addr[1],1'b0}`
  - SW: wdata=`sd`, strb=`1111`
- **Load extension:** LB/LH replicate bit 7/15; LBU/LHU zero-fill.
- `start` while `busy` is ignored and is not queued.
- `dmem_rvalid` or `dmem_gnt` in IDLE or DONE is ignored.

## Timing
- **Reset:**
  - Reset forces IDLE.
  - `busy`, `done`, `misaligned`, `dmem_req`, `dmem_we` are 0.
  - `dmem_addr`, `dmem_wdata`, `dmem_wstrb`, `load_data` are 0.
- **Reset mid-transaction:** the access is aborted, `dmem_req` is low in the cycle after reset, and a late `rvalid` is ignored.
- **Minimum load (start in cycle T, gnt in T+1, rvalid in T+2):**
  - REQ in T+1, WAIT in T+2.
  - `done` and valid `load_data` in T+3.
  - Load latency is 3 cycles.
- **Minimum store:** REQ in T+1 with gnt, `done` in T+2.
- **Error path:** DONE in T+1 with `done=misaligned=1`; `dmem_req` is never asserted.
- **Back-to-back:** the next `start` can be accepted in the cycle after `done`.
- **Outputs:** all outputs are registered or decoded from state registers only; there is no combinational path from `dmem_*` inputs to `dmem_*` outputs.

## Test plan
- **Word load:** `rst` pulse, then LW addr=0x100, gnt immediate, rvalid next cycle with rdata=0xDEADBEEF -> `dmem_addr`=0x100, `done` at T+3, `load_data`=0xDEADBEEF, `misaligned`=0.
- **Byte and half-word loads:** LB addr=0x103 with rdata=0x80112233 -> 0xFFFFFF80. LBU on the same access -> 0x00000080. LHU addr=0x102 with rdata=0xBEEF1234 -> 0x0000BEEF.
- **Stores:** SB addr=0x201, sd=0x000000A5 -> wdata=0xA5A5A5A5, strb=0010, we=1, `done` at T+2. SH addr=0x202, sd=0x1234 -> strb=1100.
- **Misaligned/illegal accesses:** SW addr=0x202 -> `done=misaligned=1` at T+1, no `dmem_req`. LH addr=0x101 gives the same response. Load with `funct3`=011 gives the same response.
- **Back-pressure:** `gnt` withheld for 5 cycles -> `dmem_req` and payload stable for all 5 cycles, `busy`=1, a second `start` is ignored, `done` follows rvalid.
- **Reset mid-WAIT:** `rst` asserted while in WAIT -> next cycle all outputs are 0 and `busy`=0. A later rvalid produces no `done`. A fresh LW then completes normally.

Source files
------------

// File: rtl/load_store_unit_if.sv
// -----------------------------------------------------------------------------
// load_store_unit_if
// Single-port data-memory bus between the load/store unit and data memory.
//   dmem_req    request valid (master -> slave)
//   dmem_we     request is a write
//   dmem_addr   word-aligned byte address
//   dmem_wdata  lane-replicated store data
//   dmem_wstrb  byte enables, zero for reads
//   dmem_gnt    memory accepts the request this cycle (slave -> master)
//   dmem_rvalid read data valid
//   dmem_rdata  read data
// -----------------------------------------------------------------------------
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                    dmem_req;
  logic                    dmem_we;
  logic [ADDR_WIDTH-1:0]   dmem_addr;
  logic [DATA_WIDTH-1:0]   dmem_wdata;
  logic [DATA_WIDTH/8-1:0] dmem_wstrb;
  logic                    dmem_gnt;
  logic                    dmem_rvalid;
  logic [DATA_WIDTH-1:0]   dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );

endinterface

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// RV32I memory-access stage. Uses the ALU result as effective address, issues
// one request on the data-memory bus and returns extended load data.
//   clk, rst        clock and synchronous active-high reset
//   start           launch an access (sampled only when idle)
//   mem_read        access is a load
//   mem_write       access is a store (wins over mem_read)
//   funct3          width/sign: B, H, W, BU, HU
//   addr            effective address
//   store_data      rs2 value
//   busy            access in flight, pipeline must stall
//   done            one-cycle completion pulse
//   misaligned      with done: access was rejected without touching memory
//   load_data       extended load result, held until the next access
//   dmem            data-memory bus (master side)
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] store_data,
  output logic                  busy,
  output logic                  done,
  output logic                  misaligned,
  output logic [DATA_WIDTH-1:0] load_data,
  load_store_unit_if.master     dmem
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]            state;
  logic [1:0]            lane_q;
  logic [2:0]            funct3_q;
  logic                  err_q;

  logic                  accept;
  logic                  legal_f3;
  logic                  aligned;
  logic [DATA_WIDTH-1:0] wdata_next;
  logic [3:0]            wstrb_next;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [DATA_WIDTH-1:0] load_ext;

  // Request and status outputs are pure state decodes, so nothing on the
  // memory side can reach them combinationally.
  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE);
  assign misaligned    = (state == S_DONE) && err_q;
  assign dmem.dmem_req = (state == S_REQ);

  // Decode of the incoming access: legality of funct3 for its direction,
  // natural alignment, and the lane-replicated store payload.
  always_comb begin
    accept     = start && (mem_read || mem_write);
    legal_f3   = 1'b0;
    aligned    = 1'b1;
    wdata_next = store_data;
    wstrb_next = 4'b1111;
    if (mem_write) begin
      legal_f3 = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    end else begin
      legal_f3 = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                 (funct3 == 3'b100) || (funct3 == 3'b101);
    end
    case (funct3[1:0])
      2'b00: begin
        wdata_next = {4{store_data[7:0]}};
        wstrb_next = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        aligned    = !addr[0];
        wdata_next = {2{store_data[15:0]}};
        wstrb_next = 4'b0011 << {addr[1], 1'b0};
      end
      2'b10: begin
        aligned = (addr[1:0] == 2'b00);
      end
      default: begin
        aligned = 1'b1;
      end
    endcase
  end

  // Lane selection and extension of returned read data, driven by the
  // address and width captured when the access was accepted.
  always_comb begin
    byte_sel = 8'h00;
    case (lane_q)
      2'd0:    byte_sel = dmem.dmem_rdata[7:0];
      2'd1:    byte_sel = dmem.dmem_rdata[15:8];
      2'd2:    byte_sel = dmem.dmem_rdata[23:16];
      default: byte_sel = dmem.dmem_rdata[31:24];
    endcase
    half_sel = lane_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_ext = {24'h000000, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_ext = {16'h0000, half_sel};
      default: load_ext = dmem.dmem_rdata;
    endcase
  end

  // Access FSM. A rejected access skips the bus entirely and reports through
  // DONE; the bus payload registers only change for accesses that go out, so
  // they stay stable for the whole REQ phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      lane_q          <= 2'd0;
      funct3_q        <= 3'd0;
      err_q           <= 1'b0;
      load_data       <= '0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_wdata <= '0;
      dmem.dmem_wstrb <= 4'b0000;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            lane_q   <= addr[1:0];
            funct3_q <= funct3;
            err_q    <= !(legal_f3 && aligned);
            if (legal_f3 && aligned) begin
              state           <= S_REQ;
              dmem.dmem_we    <= mem_write;
              dmem.dmem_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
              dmem.dmem_wdata <= mem_write ? wdata_next : '0;
              dmem.dmem_wstrb <= mem_write ? wstrb_next : 4'b0000;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_REQ: begin
          if (dmem.dmem_gnt) begin
            state <= dmem.dmem_we ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (dmem.dmem_rvalid) begin
            load_data <= load_ext;
            state     <= S_DONE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Directed bench for load_store_unit: drives accesses, plays the data memory,
// and compares completion status, load data, latency and bus payload.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic        misaligned;
  logic [31:0] load_data;

  load_store_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dmem_bus ();

  load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .busy       (busy),
    .done       (done),
    .misaligned (misaligned),
    .load_data  (load_data),
    .dmem       (dmem_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        err;
    logic [31:0] ld;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one start cycle and record what completion should look like.
  task automatic applyStimulus(input string tag, input logic rd, input logic wr,
                               input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                               input logic exp_err, input logic [31:0] exp_ld, input int exp_lat);
    exp_t e;
    e.tag = tag;
    e.err = exp_err;
    e.ld  = exp_ld;
    e.lat = exp_lat;
    sb_q.push_back(e);
    start      = 1'b1;
    mem_read   = rd;
    mem_write  = wr;
    funct3     = f3;
    addr       = a;
    store_data = sd;
    tick();
    start     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  // One full access: start, play memory (grant after gnt_delay REQ cycles,
  // rvalid one cycle after grant), then score the completion.
  task automatic do_access(input string tag, input logic rd, input logic wr,
                           input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                           input logic [31:0] rdata, input int gnt_delay, input logic spurious,
                           input logic exp_err, input logic [31:0] exp_ld,
                           input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb);
    int   n;
    int   gnt_wait;
    int   exp_lat;
    logic req_seen;
    logic granted;
    exp_t e;
    exp_lat  = exp_err ? 1 : (wr ? 2 + gnt_delay : 3 + gnt_delay);
    applyStimulus(tag, rd, wr, f3, a, sd, exp_err, exp_ld, exp_lat);
    n        = 1;
    gnt_wait = 0;
    req_seen = 1'b0;
    granted  = 1'b0;
    while (!done && n < 60) begin
      if (spurious) begin
        start      = 1'b1;
        mem_read   = 1'b1;
        mem_write  = 1'b1;
        funct3     = 3'b010;
        addr       = 32'h0000_0300;
        store_data = 32'hFFFF_0000;
      end
      if (dmem_bus.dmem_req) begin
        req_seen = 1'b1;
        checkOutput({tag, "_addr"}, dmem_bus.dmem_addr, {a[31:2], 2'b00});
        checkOutput({tag, "_we"}, {31'd0, dmem_bus.dmem_we}, {31'd0, wr});
        checkOutput({tag, "_wstrb"}, {28'd0, dmem_bus.dmem_wstrb}, {28'd0, exp_wstrb});
        if (wr) checkOutput({tag, "_wdata"}, dmem_bus.dmem_wdata, exp_wdata);
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd1);
        if (spurious) begin
          dmem_bus.dmem_rvalid = 1'b1;
          dmem_bus.dmem_rdata  = 32'hBAD0_BAD0;
        end
        if (gnt_wait == gnt_delay) begin
          dmem_bus.dmem_gnt = 1'b1;
          granted           = 1'b1;
        end else begin
          gnt_wait++;
        end
      end else if (granted && busy) begin
        dmem_bus.dmem_rvalid = 1'b1;
        dmem_bus.dmem_rdata  = rdata;
      end
      tick();
      dmem_bus.dmem_gnt    = 1'b0;
      dmem_bus.dmem_rvalid = 1'b0;
      n++;
    end
    start     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    checkOutput({tag, "_req_issued"}, {31'd0, req_seen}, {31'd0, !exp_err});
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd1);
    if (done && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checkOutput({e.tag, "_misaligned"}, {31'd0, misaligned}, {31'd0, e.err});
      checkOutput({e.tag, "_load_data"}, load_data, e.ld);
      checkOutput({e.tag, "_latency"}, n, e.lat);
    end
    tick();
    checkOutput({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    checkOutput({tag, "_idle"}, {31'd0, busy}, 32'd0);
    if (spurious) begin
      tick();
      checkOutput({tag, "_start_not_queued"}, {31'd0, busy}, 32'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
    checkOutput({tag, "_misaligned"}, {31'd0, misaligned}, 32'd0);
    checkOutput({tag, "_req"}, {31'd0, dmem_bus.dmem_req}, 32'd0);
    checkOutput({tag, "_we"}, {31'd0, dmem_bus.dmem_we}, 32'd0);
    checkOutput({tag, "_addr"}, dmem_bus.dmem_addr, 32'd0);
    checkOutput({tag, "_wdata"}, dmem_bus.dmem_wdata, 32'd0);
    checkOutput({tag, "_wstrb"}, {28'd0, dmem_bus.dmem_wstrb}, 32'd0);
    checkOutput({tag, "_load_data"}, load_data, 32'd0);
  endtask

  initial begin
    rst                  = 1'b1;
    start                = 1'b0;
    mem_read             = 1'b0;
    mem_write            = 1'b0;
    funct3               = 3'b000;
    addr                 = 32'd0;
    store_data           = 32'd0;
    dmem_bus.dmem_gnt    = 1'b0;
    dmem_bus.dmem_rvalid = 1'b0;
    dmem_bus.dmem_rdata  = 32'd0;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // start without a direction and stray memory handshakes while idle
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("no_dir_ignored", {31'd0, busy}, 32'd0);
    dmem_bus.dmem_gnt    = 1'b1;
    dmem_bus.dmem_rvalid = 1'b1;
    tick();
    dmem_bus.dmem_gnt    = 1'b0;
    dmem_bus.dmem_rvalid = 1'b0;
    checkOutput("idle_gnt_busy", {31'd0, busy}, 32'd0);
    checkOutput("idle_rvalid_done", {31'd0, done}, 32'd0);

    // loads
    do_access("lw_100",  1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 0, 32'hDEADBEEF, 32'h0, 4'b0000);
    do_access("lb_103",  1, 0, 3'b000, 32'h103, 32'h0, 32'h80112233, 0, 0, 0, 32'hFFFFFF80, 32'h0, 4'b0000);
    do_access("lbu_103", 1, 0, 3'b100, 32'h103, 32'h0, 32'h80112233, 0, 0, 0, 32'h00000080, 32'h0, 4'b0000);
    do_access("lhu_102", 1, 0, 3'b101, 32'h102, 32'h0, 32'hBEEF1234, 0, 0, 0, 32'h0000BEEF, 32'h0, 4'b0000);
    do_access("lh_100",  1, 0, 3'b001, 32'h100, 32'h0, 32'h77778001, 0, 0, 0, 32'hFFFF8001, 32'h0, 4'b0000);
    do_access("lb_101",  1, 0, 3'b000, 32'h101, 32'h0, 32'h11227F44, 0, 0, 0, 32'h0000007F, 32'h0, 4'b0000);

    // stores leave load_data untouched
    do_access("sb_201",  0, 1, 3'b000, 32'h201, 32'h000000A5, 32'h0, 0, 0, 0, 32'h0000007F, 32'hA5A5A5A5, 4'b0010);
    do_access("sh_202",  0, 1, 3'b001, 32'h202, 32'h00001234, 32'h0, 0, 0, 0, 32'h0000007F, 32'h12341234, 4'b1100);
    do_access("sw_204",  0, 1, 3'b010, 32'h204, 32'hCAFEBABE, 32'h0, 1, 0, 0, 32'h0000007F, 32'hCAFEBABE, 4'b1111);
    do_access("sb_both", 1, 1, 3'b000, 32'h203, 32'h1111115A, 32'h0, 0, 0, 0, 32'h0000007F, 32'h5A5A5A5A, 4'b1000);

    // rejected accesses
    do_access("sw_202_mis", 0, 1, 3'b010, 32'h202, 32'h12345678, 32'h0, 0, 0, 1, 32'h0000007F, 32'h0, 4'b0000);
    do_access("lh_101_mis", 1, 0, 3'b001, 32'h101, 32'h0, 32'h0, 0, 0, 1, 32'h0000007F, 32'h0, 4'b0000);
    do_access("lw_101_mis", 1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 0, 1, 32'h0000007F, 32'h0, 4'b0000);
    do_access("ld_f3_011",  1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0, 1, 32'h0000007F, 32'h0, 4'b0000);
    do_access("st_f3_100",  0, 1, 3'b100, 32'h100, 32'h0, 32'h0, 0, 0, 1, 32'h0000007F, 32'h0, 4'b0000);

    // back-pressure: grant withheld five cycles, second start ignored
    do_access("lw_bp", 1, 0, 3'b010, 32'h104, 32'h0, 32'h55667788, 5, 1, 0, 32'h55667788, 32'h0, 4'b0000);

    // reset while waiting for read data
    start    = 1'b1;
    mem_read = 1'b1;
    funct3   = 3'b010;
    addr     = 32'h108;
    tick();
    start    = 1'b0;
    mem_read = 1'b0;
    checkOutput("rstw_req", {31'd0, dmem_bus.dmem_req}, 32'd1);
    dmem_bus.dmem_gnt = 1'b1;
    tick();
    dmem_bus.dmem_gnt = 1'b0;
    checkOutput("rstw_wait_busy", {31'd0, busy}, 32'd1);
    checkOutput("rstw_wait_req", {31'd0, dmem_bus.dmem_req}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("rstw_after");
    for (int i = 0; i < 3; i++) begin
      dmem_bus.dmem_rvalid = 1'b1;
      dmem_bus.dmem_rdata  = 32'h12345678;
      tick();
      checkOutput("rstw_late_rvalid_done", {31'd0, done}, 32'd0);
      checkOutput("rstw_late_rvalid_busy", {31'd0, busy}, 32'd0);
    end
    dmem_bus.dmem_rvalid = 1'b0;
    do_access("lw_after_rst", 1, 0, 3'b010, 32'h10C, 32'h0, 32'h0BADF00D, 0, 0, 0, 32'h0BADF00D, 32'h0, 4'b0000);

    checkOutput("scoreboard_empty", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
